count_sampler: RTL and testbench

Synchronous capture stage directly downstream of the 4-bit asynchronous MOD-5 ripple counter. It brings the counter's ripple outputs into the system clock domain and rejects the transient codes produced while the ripple settles. It tracks the accepted value and emits single-cycle step, wrap and error pulses, keeping a wrap tally for the control logic that consumes the count.

---
 rtl/count_sampler_pkg.sv | 22 ++
 rtl/count_sampler_if.sv | 26 ++
 rtl/sync2.sv | 32 +++
 rtl/count_sampler.sv | 155 +++++++++++++++
 tb/tb_count_sampler.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/count_sampler_pkg.sv
// Shared types and defaults for the ripple-counter capture stage.
package count_sampler_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_e;

  localparam int DEF_MOD           = 5;
  localparam int DEF_STABLE_CYCLES = 3;
  localparam int DEF_WRAP_W        = 8;

  // Successor of a legal code in a MOD-n sequence.
  function automatic logic [3:0] next_code(input logic [3:0] p, input int modulus);
    if (int'(p) >= modulus - 1) begin
      return 4'd0;
    end
    return 4'(int'(p) + 1);
  endfunction

endpackage

// File: rtl/count_sampler_if.sv
// Signal bundle between the ripple-counter consumer logic and count_sampler.
interface count_sampler_if #(
  parameter int WRAP_W = 8
) ();
  // No backpressure: valid is a level meaning count_q holds an accepted value,
  // and step/wrap/error are single-cycle strobes the consumer must take as they come.
  logic [3:0]        y_in;
  logic              clear;
  logic [3:0]        count_q;
  logic              valid;
  logic              step;
  logic              wrap;
  logic              error;
  logic              err_flag;
  logic [WRAP_W-1:0] wrap_count;

  modport master (
    output y_in, clear,
    input  count_q, valid, step, wrap, error, err_flag, wrap_count
  );

  modport slave (
    input  y_in, clear,
    output count_q, valid, step, wrap, error, err_flag, wrap_count
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer, one chain per bit, for a bus that only changes
// through settled codes filtered downstream.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/count_sampler.sv
// Captures an asynchronous MOD-n ripple counter: synchronize, reject ripple
// transients, track the accepted value and report step/wrap/error events.
module count_sampler
  import count_sampler_pkg::*;
#(
  parameter int MOD           = DEF_MOD,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int WRAP_W        = DEF_WRAP_W
) (
  input  logic            clock,
  input  logic            reset,
  count_sampler_if.slave  bus,
  output state_e          dbg_state
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);

  logic [3:0] s2;

  sync2 #(.W(4)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.y_in),
    .q     (s2)
  );

  // Stability filter state
  logic [3:0]       cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             accept;

  // Tracking state and registered outputs
  state_e            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              valid_q, valid_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic              error_q, error_d;
  logic              err_flag_q, err_flag_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  // run saturates at STABLE_CYCLES so a held value is accepted exactly once.
  always_comb begin
    cand_d = cand_q;
    run_d  = run_q;
    accept = 1'b0;
    if (s2 != cand_q) begin
      cand_d = s2;
      run_d  = RUN_W'(1);
    end else begin
      if (run_q < RUN_W'(STABLE_CYCLES)) begin
        run_d = run_q + RUN_W'(1);
      end
      if (run_q == RUN_W'(STABLE_CYCLES - 1)) begin
        accept = 1'b1;
      end
    end
    if (bus.clear) begin
      run_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    valid_d    = valid_q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    error_d    = 1'b0;
    err_flag_d = err_flag_q;
    wrap_cnt_d = wrap_cnt_q;

    if (bus.clear) begin
      state_d    = INIT;
      valid_d    = 1'b0;
      err_flag_d = 1'b0;
      wrap_cnt_d = '0;
    end else if (accept) begin
      count_d = cand_q;
      valid_d = 1'b1;
      unique case (state_q)
        INIT: begin
          if (int'(cand_q) < MOD) begin
            state_d = TRACK;
          end else begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_flag_d = 1'b1;
          end
        end
        TRACK: begin
          if (int'(cand_q) < MOD && cand_q == next_code(count_q, MOD)) begin
            step_d = 1'b1;
            if (int'(count_q) == MOD - 1 && cand_q == 4'd0) begin
              wrap_d = 1'b1;
              if (wrap_cnt_q != '1) begin
                wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
              end
            end
          end else begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_flag_d = 1'b1;
          end
        end
        ERROR: begin
          // Only clear leaves ERROR; skips here are expected and not re-flagged.
          if (int'(cand_q) >= MOD) begin
            error_d    = 1'b1;
            err_flag_d = 1'b1;
          end
        end
        default: begin
          state_d = INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand_q     <= '0;
      run_q      <= '0;
      state_q    <= INIT;
      count_q    <= '0;
      valid_q    <= 1'b0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      error_q    <= 1'b0;
      err_flag_q <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      cand_q     <= cand_d;
      run_q      <= run_d;
      state_q    <= state_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      error_q    <= error_d;
      err_flag_q <= err_flag_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign bus.count_q    = count_q;
  assign bus.valid      = valid_q;
  assign bus.step       = step_q;
  assign bus.wrap       = wrap_q;
  assign bus.error      = error_q;
  assign bus.err_flag   = err_flag_q;
  assign bus.wrap_count = wrap_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_count_sampler.sv
// Directed bench for count_sampler: reset, stepping, ripple transients,
// illegal codes, clear, wrap saturation and asynchronous reset.
module tb_count_sampler;
  import count_sampler_pkg::*;

  logic   clock;
  logic   reset;
  state_e dbg_state;

  count_sampler_if #(.WRAP_W(8)) bus ();

  count_sampler #(.MOD(5), .STABLE_CYCLES(3), .WRAP_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // pulse monitors, sampled mid-cycle
  int n_step = 0, n_wrap = 0, n_error = 0, n_wrap_alone = 0, n_code2 = 0;
  always @(negedge clock) begin
    if (reset) begin
      n_step  += int'(bus.step);
      n_wrap  += int'(bus.wrap);
      n_error += int'(bus.error);
      if (bus.wrap && !bus.step) n_wrap_alone++;
      if (bus.valid && bus.count_q == 4'd2) n_code2++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // driver: present a code and hold it for n edges
  task automatic drive(input logic [3:0] v, input int n);
    bus.y_in = v;
    edges(n);
  endtask

  int s_step, s_wrap, s_err, s_alone, s_code2;
  task automatic snap();
    s_step  = n_step;
    s_wrap  = n_wrap;
    s_err   = n_error;
    s_alone = n_wrap_alone;
    s_code2 = n_code2;
  endtask

  initial begin
    reset     = 1'b0;
    bus.y_in  = 4'd0;
    bus.clear = 1'b0;
    #22;
    chk("rst_count", 32'(bus.count_q), 0);
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_err_flag", 32'(bus.err_flag), 0);
    chk("rst_wrap_count", 32'(bus.wrap_count), 0);
    chk("rst_state", 32'(dbg_state), 32'(INIT));
    @(posedge clock);
    #1;
    reset = 1'b1;

    // first accept of the held 0
    edges(4);
    chk("init_valid", 32'(bus.valid), 1);
    chk("init_count", 32'(bus.count_q), 0);
    chk("init_state", 32'(dbg_state), 32'(TRACK));
    chk("init_pulses", 32'(n_step + n_wrap + n_error), 0);

    // 0 -> 1 with exact latency: still old value after 4 edges, new on the 5th
    snap();
    drive(4'd1, 4);
    chk("lat_before", 32'(bus.count_q), 0);
    edges(1);
    chk("lat_count", 32'(bus.count_q), 1);
    chk("lat_step", 32'(bus.step), 1);
    edges(1);
    chk("lat_step_width", 32'(bus.step), 0);
    edges(3);
    drive(4'd2, 10);
    drive(4'd3, 10);
    drive(4'd4, 10);
    drive(4'd0, 5);
    chk("wrap_pulse", 32'(bus.wrap), 1);
    chk("wrap_step", 32'(bus.step), 1);
    edges(5);
    chk("seq_steps", 32'(n_step - s_step), 5);
    chk("seq_wraps", 32'(n_wrap - s_wrap), 1);
    chk("seq_wrap_alone", 32'(n_wrap_alone - s_alone), 0);
    chk("seq_wrap_count", 32'(bus.wrap_count), 1);
    chk("seq_err_flag", 32'(bus.err_flag), 0);
    chk("seq_count", 32'(bus.count_q), 0);

    // ripple transient 3 -> (2 for one cycle) -> 4
    drive(4'd1, 10);
    drive(4'd2, 10);
    drive(4'd3, 10);
    snap();
    drive(4'd2, 1);
    drive(4'd4, 10);
    chk("glitch_count", 32'(bus.count_q), 4);
    chk("glitch_steps", 32'(n_step - s_step), 1);
    chk("glitch_errors", 32'(n_error - s_err), 0);
    chk("glitch_never2", 32'(n_code2 - s_code2), 0);

    // illegal code from TRACK with count_q = 4
    snap();
    drive(4'd6, 5);
    chk("ill_error", 32'(bus.error), 1);
    chk("ill_err_flag", 32'(bus.err_flag), 1);
    chk("ill_count", 32'(bus.count_q), 6);
    chk("ill_state", 32'(dbg_state), 32'(ERROR));
    edges(5);
    chk("ill_error_once", 32'(n_error - s_err), 1);
    snap();
    drive(4'd0, 10);
    chk("err_follow0", 32'(bus.count_q), 0);
    chk("err_no_pulses", 32'(n_step - s_step + n_wrap - s_wrap + n_error - s_err), 0);
    chk("err_wrap_count", 32'(bus.wrap_count), 1);

    // clear while in ERROR with 2 held
    drive(4'd2, 10);
    snap();
    bus.clear = 1'b1;
    edges(1);
    bus.clear = 1'b0;
    chk("clr_valid", 32'(bus.valid), 0);
    chk("clr_wrap_count", 32'(bus.wrap_count), 0);
    chk("clr_err_flag", 32'(bus.err_flag), 0);
    chk("clr_count_held", 32'(bus.count_q), 2);
    chk("clr_state", 32'(dbg_state), 32'(INIT));
    edges(4);
    chk("clr_reaccept_valid", 32'(bus.valid), 1);
    chk("clr_reaccept_count", 32'(bus.count_q), 2);
    chk("clr_reaccept_state", 32'(dbg_state), 32'(TRACK));
    chk("clr_no_pulses", 32'(n_step - s_step + n_wrap - s_wrap + n_error - s_err), 0);

    // wrap tally up to and past saturation
    drive(4'd3, 6);
    drive(4'd4, 6);
    snap();
    for (int w = 0; w < 255; w++) begin
      for (int c = 0; c < 5; c++) begin
        logic [3:0] code;
        code = (c == 4) ? 4'd4 : 4'(c);
        drive(code, 6);
      end
    end
    chk("sat_reach", 32'(bus.wrap_count), 255);
    for (int w = 0; w < 5; w++) begin
      for (int c = 0; c < 5; c++) begin
        logic [3:0] code;
        code = 4'(c);
        drive(code, 6);
      end
    end
    chk("sat_hold", 32'(bus.wrap_count), 255);
    chk("sat_wraps", 32'(n_wrap - s_wrap), 260);
    chk("sat_errors", 32'(n_error - s_err), 0);
    chk("sat_err_flag", 32'(bus.err_flag), 0);

    // asynchronous reset mid-sequence, between clock edges
    drive(4'd0, 5);
    chk("pre_rst_step", 32'(bus.step), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count_q), 0);
    chk("arst_valid", 32'(bus.valid), 0);
    chk("arst_step", 32'(bus.step), 0);
    chk("arst_wrap", 32'(bus.wrap), 0);
    chk("arst_error", 32'(bus.error), 0);
    chk("arst_err_flag", 32'(bus.err_flag), 0);
    chk("arst_wrap_count", 32'(bus.wrap_count), 0);
    chk("arst_state", 32'(dbg_state), 32'(INIT));
    edges(2);
    chk("arst_held_valid", 32'(bus.valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
